// File: rtl/fft_pkg.sv
// Shared definitions for the FFT input loader: one-hot loader states, default sizes,
// and a bit-reversal helper used to build in-place radix-2 DIT write addresses.
package fft_pkg;

  localparam int FFT_N         = 16;
  localparam int FFT_SIZE      = 4;
  localparam int FFT_BIT_WIDTH = 29;
  localparam int FFT_IN_W      = 16;

  typedef enum logic [3:0] {
    ST_LOAD     = 4'b0001,
    ST_FLUSH    = 4'b0010,
    ST_START    = 4'b0100,
    ST_WAIT_FFT = 4'b1000
  } load_state_e;

  // Reverses the low 'size' bits of 'value'; bits at and above 'size' come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int size);
    logic [31:0] w_rev;
    w_rev = {<<{value}};
    return w_rev >> (32 - size);
  endfunction

endpackage

// File: rtl/fft_bitrev_addr.sv
// Combinational SIZE-bit address reversal for the loader write port.
// With FFT_LOAD_BITREV_EN undefined it passes the index through unchanged.
module fft_bitrev_addr
  import fft_pkg::*;
#(
  parameter int SIZE = FFT_SIZE
) (
  input  logic [SIZE-1:0] i_idx,
  output logic [SIZE-1:0] o_addr
);

`ifdef FFT_LOAD_BITREV_EN
  assign o_addr = SIZE'(bitrev(32'(i_idx), SIZE));
`else
  assign o_addr = i_idx;
`endif

endmodule

// File: rtl/fft_input_loader.sv
// Loads one N-point frame from a valid/ready stream into the FFT working RAM, then pulses
// flag_start_FFT and holds off input until fft_done. Bit-reversed addressing under FFT_LOAD_BITREV_EN.
module fft_input_loader
  import fft_pkg::*;
#(
  parameter int bit_width = FFT_BIT_WIDTH,
  parameter int IN_W      = FFT_IN_W,
  parameter int N         = FFT_N,
  parameter int SIZE      = FFT_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [IN_W-1:0]      in_re,
  input  logic [IN_W-1:0]      in_im,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic [SIZE-1:0]      wr_addr,
  output logic [bit_width-1:0] wr_re,
  output logic [bit_width-1:0] wr_im,
  output logic                 flag_start_FFT,
  input  logic                 fft_done,
  output logic                 busy
);

  localparam logic [SIZE-1:0] CNT_LAST = SIZE'(N - 1);

  load_state_e          r_state;
  load_state_e          w_state_nxt;
  logic [SIZE-1:0]      r_cnt;
  logic                 r_in_ready;
  logic                 r_busy;
  logic                 r_wr_en;
  logic [SIZE-1:0]      r_wr_addr;
  logic [bit_width-1:0] r_wr_re;
  logic [bit_width-1:0] r_wr_im;
  logic [SIZE-1:0]      w_addr;
  logic                 w_xfer;
  logic                 w_last;
  logic                 w_done_ack;
  logic                 w_flag_start;

  fft_bitrev_addr #(.SIZE(SIZE)) u_bitrev (
    .i_idx  (r_cnt),
    .o_addr (w_addr)
  );

  assign w_xfer     = in_valid && r_in_ready && (r_state == ST_LOAD);
  assign w_last     = w_xfer && (r_cnt == CNT_LAST);
  assign w_done_ack = fft_done && (r_state == ST_WAIT_FFT);

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_flag_start = 1'b0;
    case (r_state)
      ST_LOAD:     if (w_last) w_state_nxt = ST_FLUSH;
      ST_FLUSH:    w_state_nxt = ST_START;
      ST_START: begin
        w_flag_start = 1'b1;
        w_state_nxt  = ST_WAIT_FFT;
      end
      ST_WAIT_FFT: if (fft_done) w_state_nxt = ST_LOAD;
      default:     w_state_nxt = ST_LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_LOAD;
    else        r_state <= w_state_nxt;
  end

  // in_ready comes up one cycle after reset release and drops on the frame's last transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      if (r_state == ST_LOAD) r_in_ready <= !w_last;
      else                    r_in_ready <= w_done_ack;

      if (w_xfer) begin
        r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
        r_busy <= 1'b1;
      end else if (w_done_ack) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Registered write port: one cycle after a transfer, data sign-extended to the RAM width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_re   <= '0;
      r_wr_im   <= '0;
    end else begin
      r_wr_en <= w_xfer;
      if (w_xfer) begin
        r_wr_addr <= w_addr;
        r_wr_re   <= bit_width'($signed(in_re));
        r_wr_im   <= bit_width'($signed(in_im));
      end
    end
  end

  assign in_ready       = r_in_ready;
  assign busy           = r_busy;
  assign wr_en          = r_wr_en;
  assign wr_addr        = r_wr_addr;
  assign wr_re          = r_wr_re;
  assign wr_im          = r_wr_im;
  assign flag_start_FFT = w_flag_start;

endmodule

// File: tb/tb_fft_input_loader.sv
// Scoreboard bench for fft_input_loader: an input observer pushes expected writes and start
// pulses from a frame-level model; a negedge monitor pops and compares. FFT_LOAD_BITREV_EN selects address order.
module tb_fft_input_loader;

  localparam int BW   = 29;
  localparam int IW   = 16;
  localparam int NPTS = 16;
  localparam int SZ   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [IW-1:0] in_re = '0;
  logic [IW-1:0] in_im = '0;
  logic          fft_done = 1'b0;
  logic          in_ready;
  logic          wr_en;
  logic [SZ-1:0] wr_addr;
  logic [BW-1:0] wr_re;
  logic [BW-1:0] wr_im;
  logic          flag_start_FFT;
  logic          busy;

  fft_input_loader #(.bit_width(BW), .IN_W(IW), .N(NPTS), .SIZE(SZ)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_re          (in_re),
    .in_im          (in_im),
    .in_ready       (in_ready),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_re          (wr_re),
    .wr_im          (wr_im),
    .flag_start_FFT (flag_start_FFT),
    .fft_done       (fft_done),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int            cyc;
    logic [SZ-1:0] addr;
    logic [BW-1:0] re;
    logic [BW-1:0] im;
  } wr_t;

  wr_t exp_q[$];
  int  start_q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  n_acc = 0;
  int  n_start = 0;
  int  k = 0;
  int  m_start_cyc = 0;
  bit  m_wait = 1'b0;
  bit  m_rdy = 1'b0;
  bit  m_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input string detail);
    total++;
    bad++;
    $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
  endtask

  function automatic logic [SZ-1:0] exp_addr(input int idx);
`ifdef FFT_LOAD_BITREV_EN
    int r = 0;
    for (int b = 0; b < SZ; b++) r = r * 2 + ((idx >> b) & 1);
    return SZ'(r);
`else
    return SZ'(idx);
`endif
  endfunction

  // Frame-level model: sample index within the frame, wait-for-done phase, expected ready/busy.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      exp_q.delete();
      start_q.delete();
      k = 0;
      m_wait = 1'b0;
      m_rdy = 1'b0;
      m_busy = 1'b0;
    end else if (m_wait) begin
      if (fft_done && cyc >= m_start_cyc + 2) begin
        m_wait = 1'b0;
        m_rdy = 1'b1;
        m_busy = 1'b0;
      end
    end else begin
      m_rdy = 1'b1;
      if (in_valid && in_ready) begin
        exp_q.push_back('{cyc: cyc, addr: exp_addr(k),
                          re: BW'(int'($signed(in_re))), im: BW'(int'($signed(in_im)))});
        n_acc++;
        k++;
        m_busy = 1'b1;
        if (k == NPTS) begin
          k = 0;
          m_wait = 1'b1;
          m_rdy = 1'b0;
          m_start_cyc = cyc + 1;
          start_q.push_back(cyc + 1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      wr_t e;
      int  s;
      check("in_ready", 64'(in_ready), 64'(m_rdy));
      check("busy", 64'(busy), 64'(m_busy));
      if (wr_en) begin
        if (exp_q.size() == 0) fail("unexpected_write", "got wr_en=1, required 0");
        else begin
          e = exp_q.pop_front();
          check("wr_cycle", 64'(cyc), 64'(e.cyc));
          check("wr_addr", 64'(wr_addr), 64'(e.addr));
          check("wr_re", 64'(wr_re), 64'(e.re));
          check("wr_im", 64'(wr_im), 64'(e.im));
        end
      end
      if (flag_start_FFT) begin
        n_start++;
        if (start_q.size() == 0) fail("unexpected_start", "got flag_start_FFT=1, required 0");
        else begin
          s = start_q.pop_front();
          check("start_cycle", 64'(cyc), 64'(s));
        end
      end else if (start_q.size() > 0 && start_q[0] <= cyc) begin
        s = start_q.pop_front();
        fail("start_missing", $sformatf("got no pulse, required pulse at cycle %0d", s));
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_re", 64'(wr_re), 64'd0);
    check("rst_wr_im", 64'(wr_im), 64'd0);
    check("rst_flag", 64'(flag_start_FFT), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
  endtask

  // Sends 'count' samples; a stalled beat keeps valid and data until accepted.
  task automatic drive(input int count, input bit gaps, input bit ramp);
    int base = n_acc;
    int last = n_acc;
    int budget = 0;
    int idx;
    forever begin
      @(negedge clk);
      if (n_acc - base >= count) break;
      budget++;
      if (budget > 1000) begin
        fail("drive_timeout", $sformatf("got %0d accepted, required %0d", n_acc - base, count));
        break;
      end
      if (in_valid && n_acc == last) continue;
      last = n_acc;
      idx = n_acc - base;
      if (gaps && $urandom_range(0, 1) == 1) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        if (ramp) begin
          in_re = IW'(idx);
          in_im = IW'(-idx);
        end else begin
          in_re = IW'($urandom);
          in_im = IW'($urandom);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_start(input int target);
    int b = 0;
    while (n_start < target && b < 50) begin
      @(negedge clk);
      b++;
    end
    check("start_seen", 64'(n_start), 64'(target));
  endtask

  task automatic pulse_done();
    @(negedge clk);
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #2 check_reset_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Continuous ramp frame: re=k, im=-k.
    drive(NPTS, 1'b0, 1'b1);
    wait_start(1);
    repeat (3) @(negedge clk);
    pulse_done();

    // Random valid gaps.
    drive(NPTS, 1'b1, 1'b0);
    wait_start(2);

    // Valid held high while waiting for the sequencer.
    @(negedge clk);
    in_valid = 1'b1;
    in_re = IW'($urandom);
    in_im = IW'($urandom);
    repeat (100) @(negedge clk);
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
    drive(NPTS, 1'b0, 1'b0);
    wait_start(3);
    pulse_done();

    // fft_done during LOAD is ignored.
    drive(5, 1'b1, 1'b0);
    pulse_done();
    drive(NPTS - 5, 1'b1, 1'b0);
    wait_start(4);
    pulse_done();

    // Reset mid-frame discards the partial frame.
    drive(7, 1'b0, 1'b0);
    apply_reset();
    drive(NPTS, 1'b0, 1'b0);
    wait_start(5);
    pulse_done();

    repeat (5) @(negedge clk);
    check("writes_drained", 64'(exp_q.size()), 64'd0);
    check("starts_drained", 64'(start_q.size()), 64'd0);
    check("start_count", 64'(n_start), 64'd5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
